// File: rtl/wishbone_initiator.sv
// wishbone_initiator
//   Converts single-beat read/write requests into Wishbone classic bus cycles
//   on a big-endian 32-bit data bus, with retry and timeout handling.
//
// Ports
//   clk_i, rst_i              : rising-edge clock, asynchronous active-low reset
//   req_valid_i / req_ready_o : request handshake (ready only while idle)
//   req_addr_i                : byte address
//   req_we_i                  : 1 = write, 0 = read
//   req_size_i                : 0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_wdata_i               : right-aligned write data
//   resp_valid_o              : one-cycle response pulse
//   resp_rdata_o              : right-aligned, zero-extended read data (0 for writes/errors)
//   resp_err_o                : response error flag
//   cyc_o, stb_o, we_o, adr_o, sel_o, dat_o, dat_i, ack_i, err_i, rty_i
//                             : Wishbone classic initiator signals
module wishbone_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    // Timer holds 0 .. TIMEOUT_CYCLES-1; the last value is the final BUS cycle.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t          state_reg;
    logic [1:0]      size_reg;
    logic [1:0]      off_reg;
    logic [TW-1:0]   timer_reg;
    logic [RW-1:0]   retry_reg;

    // Request decode (evaluated on the live request inputs at acceptance)
    logic            req_misaligned;
    logic [3:0]      req_sel;
    logic [31:0]     req_lanes;

    always_comb begin
        req_misaligned = 1'b0;
        req_sel        = 4'b1111;
        req_lanes      = req_wdata_i;
        case (req_size_i)
            2'd0: begin
                req_sel   = 4'b1000 >> req_addr_i[1:0];
                req_lanes = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                req_misaligned = req_addr_i[0];
                req_sel        = req_addr_i[1] ? 4'b0011 : 4'b1100;
                req_lanes      = {2{req_wdata_i[15:0]}};
            end
            2'd2: begin
                req_misaligned = |req_addr_i[1:0];
            end
            default: begin
                req_misaligned = 1'b1;
            end
        endcase
    end

    // Byte lane k of the bus sits at dat[31-8k -: 8] (big-endian).
    logic [7:0] rd_lane [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_lane[gi] = dat_i[31 - 8*gi -: 8];
        end
    endgenerate

    logic [31:0] rd_aligned;
    always_comb begin
        rd_aligned = dat_i;
        case (size_reg)
            2'd0:    rd_aligned = {24'd0, rd_lane[off_reg]};
            2'd1:    rd_aligned = off_reg[1] ? {16'd0, rd_lane[2], rd_lane[3]}
                                             : {16'd0, rd_lane[0], rd_lane[1]};
            default: rd_aligned = dat_i;
        endcase
    end

    // Termination decode for the BUS state: err > ack > rty, then timeout.
    logic bus_finish;
    logic bus_fail;
    logic bus_retry;
    always_comb begin
        bus_finish = 1'b0;
        bus_fail   = 1'b0;
        bus_retry  = 1'b0;
        if (err_i) begin
            bus_finish = 1'b1;
            bus_fail   = 1'b1;
        end else if (ack_i) begin
            bus_finish = 1'b1;
        end else if (rty_i) begin
            if (retry_reg < RETRY_MAX) begin
                bus_retry = 1'b1;
            end else begin
                bus_finish = 1'b1;
                bus_fail   = 1'b1;
            end
        end else if (timer_reg == TIMER_LAST) begin
            bus_finish = 1'b1;
            bus_fail   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= IDLE;
            size_reg     <= 2'd0;
            off_reg      <= 2'd0;
            timer_reg    <= '0;
            retry_reg    <= '0;
            req_ready_o  <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'd0;
            resp_err_o   <= 1'b0;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            we_o         <= 1'b0;
            adr_o        <= 32'd0;
            sel_o        <= 4'd0;
            dat_o        <= 32'd0;
        end else begin
            resp_valid_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    retry_reg <= '0;
                    if (req_ready_o && req_valid_i) begin
                        req_ready_o <= 1'b0;
                        size_reg    <= req_size_i;
                        off_reg     <= req_addr_i[1:0];
                        timer_reg   <= '0;
                        if (req_misaligned) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg <= BUS;
                            cyc_o     <= 1'b1;
                            stb_o     <= 1'b1;
                            we_o      <= req_we_i;
                            adr_o     <= req_addr_i;
                            sel_o     <= req_sel;
                            dat_o     <= req_we_i ? req_lanes : 32'd0;
                        end
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                BUS: begin
                    if (bus_finish) begin
                        state_reg    <= RESP;
                        cyc_o        <= 1'b0;
                        stb_o        <= 1'b0;
                        we_o         <= 1'b0;
                        adr_o        <= 32'd0;
                        sel_o        <= 4'd0;
                        dat_o        <= 32'd0;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= bus_fail;
                        resp_rdata_o <= (bus_fail || we_o) ? 32'd0 : rd_aligned;
                    end else if (bus_retry) begin
                        state_reg <= BACKOFF;
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        retry_reg <= retry_reg + 1'b1;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                BACKOFF: begin
                    // Address/data/select stay latched; only the strobe pair drops.
                    state_reg <= BUS;
                    cyc_o     <= 1'b1;
                    stb_o     <= 1'b1;
                    timer_reg <= '0;
                end
                RESP: begin
                    // Bus-terminated responses arrive with the pulse already set.
                    // A misaligned request enters here with no pulse yet, so it
                    // spends one extra cycle raising its error response.
                    if (resp_valid_o) begin
                        state_reg   <= IDLE;
                        req_ready_o <= 1'b1;
                    end else begin
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b1;
                        resp_rdata_o <= 32'd0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_initiator.sv
module tb_wishbone_initiator;

    localparam int TO = 8;
    localparam int MR = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i, rty_i;

    always #5 clk_i = ~clk_i;

    wishbone_initiator #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Observations of one transaction, cycle 1 = first cycle after acceptance
    int          obs_attempts, obs_cyc_cycles, obs_first_cyc, obs_resp_cycle, obs_pulses;
    logic [31:0] obs_rdata, obs_adr, obs_dat;
    logic        obs_err, obs_we;
    logic [3:0]  obs_sel;
    bit          obs_stable, obs_gap_bad, obs_ready_busy_bad, obs_ready_after, obs_hold_ok;

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic bit m_mis(logic [31:0] a, logic [1:0] s);
        int n;
        if (s == 2'd3) return 1'b1;
        n = 1 << s;
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] m_sel(logic [31:0] a, logic [1:0] s);
        int n, off;
        logic [3:0] r;
        n = 1 << s; off = int'(a % 4); r = 4'd0;
        for (int k = 0; k < 4; k++)
            if (k >= off && k < off + n) r[3-k] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wdat(logic [31:0] wd, logic [1:0] s);
        int n;
        logic [31:0] r, b;
        n = 1 << s; r = 32'd0;
        for (int k = 0; k < 4; k++) begin
            b = (wd >> (8 * ((n - 1) - (k % n)))) & 32'hFF;
            r = r | (b << (8 * (3 - k)));
        end
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(logic [31:0] d, logic [31:0] a, logic [1:0] s);
        int n, off;
        logic [31:0] mask;
        n = 1 << s; off = int'(a % 4);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        return (d >> (8 * (4 - off - n))) & mask;
    endfunction

    // ---------------- transaction engine with behavioural responder ----------------
    // Entered and left just after a falling edge. The responder terminates in the
    // second cycle of every strobe: n_rty retries first, then err or ack.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [1:0] size,
                           input logic [31:0] wdata, input int n_rty, input bit final_err,
                           input bit silent, input logic [31:0] rd_data);
        int  c, att_cyc, gap, wait_n;
        bit  prev_cyc;
        obs_attempts = 0; obs_cyc_cycles = 0; obs_first_cyc = 0; obs_resp_cycle = 0;
        obs_pulses = 0; obs_rdata = 32'd0; obs_err = 1'b0; obs_adr = 32'd0; obs_dat = 32'd0;
        obs_we = 1'b0; obs_sel = 4'd0; obs_stable = 1'b1; obs_gap_bad = 1'b0;
        obs_ready_busy_bad = 1'b0; obs_ready_after = 1'b0; obs_hold_ok = 1'b0;
        wait_n = 0;
        while (req_ready_o !== 1'b1 && wait_n < 50) begin
            @(negedge clk_i);
            wait_n++;
        end
        req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we; req_size_i = size; req_wdata_i = wdata;
        @(negedge clk_i);
        req_valid_i = 1'b0; req_addr_i = $urandom; req_we_i = 1'b0; req_size_i = 2'($urandom);
        req_wdata_i = $urandom;
        c = 1; prev_cyc = 1'b0; att_cyc = 0; gap = 0;
        while (c <= 60 && !(obs_resp_cycle > 0 && c > obs_resp_cycle + 1)) begin
            if (cyc_o === 1'b1) begin
                obs_cyc_cycles++;
                if (!prev_cyc) begin
                    obs_attempts++;
                    att_cyc = 0;
                    if (obs_attempts == 1) begin
                        obs_first_cyc = c; obs_we = we_o; obs_adr = adr_o; obs_sel = sel_o; obs_dat = dat_o;
                    end else if (gap != 1) begin
                        obs_gap_bad = 1'b1;
                    end
                end
                if (stb_o !== 1'b1 || we_o !== obs_we || adr_o !== obs_adr ||
                    sel_o !== obs_sel || dat_o !== obs_dat)
                    obs_stable = 1'b0;
                att_cyc++;
            end else begin
                if (prev_cyc) gap = 0;
                gap++;
                if (stb_o !== 1'b0) obs_stable = 1'b0;
            end
            if (resp_valid_o === 1'b1) begin
                obs_pulses++;
                if (obs_resp_cycle == 0) begin
                    obs_resp_cycle = c; obs_rdata = resp_rdata_o; obs_err = resp_err_o;
                end
            end
            if (req_ready_o === 1'b1 && (obs_resp_cycle == 0 || c <= obs_resp_cycle))
                obs_ready_busy_bad = 1'b1;
            if (obs_resp_cycle > 0 && c == obs_resp_cycle + 1) begin
                obs_ready_after = req_ready_o;
                obs_hold_ok = (resp_rdata_o === obs_rdata) && (resp_err_o === obs_err);
            end
            ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = $urandom;
            if (cyc_o === 1'b1 && stb_o === 1'b1 && att_cyc == 2 && !silent) begin
                if (obs_attempts <= n_rty) rty_i = 1'b1;
                else if (final_err)        err_i = 1'b1;
                else begin
                    ack_i = 1'b1; dat_i = rd_data;
                end
            end
            prev_cyc = (cyc_o === 1'b1);
            @(negedge clk_i);
            c++;
        end
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        $display("txn addr=%h we=%0b size=%0d attempts=%0d resp_cycle=%0d err=%0b rdata=%h",
                 addr, we, size, obs_attempts, obs_resp_cycle, obs_err, obs_rdata);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if ({cyc_o, stb_o, we_o, req_ready_o, resp_valid_o, resp_err_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b expected 000000",
                     {cyc_o, stb_o, we_o, req_ready_o, resp_valid_o, resp_err_o});
        end
        n_cmp++;
        if ({adr_o, sel_o, dat_o, resp_rdata_o} !== 100'd0) begin
            n_fail++;
            $display("FAIL reset_data got adr=%h sel=%h dat=%h rdata=%h expected all 0",
                     adr_o, sel_o, dat_o, resp_rdata_o);
        end
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if (req_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_pre got %b expected 0", req_ready_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_post got %b expected 1", req_ready_o);
        end
    endtask

    task automatic test_read_word();
        run_txn(32'h100, 1'b0, 2'd2, 32'd0, 0, 1'b0, 1'b0, 32'hDEADBEEF);
        n_cmp++;
        if (obs_sel !== 4'b1111) begin n_fail++; $display("FAIL rw_sel got %b expected 1111", obs_sel); end
        n_cmp++;
        if (obs_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rw_rdata got %h expected deadbeef", obs_rdata); end
        n_cmp++;
        if (obs_err !== 1'b0) begin n_fail++; $display("FAIL rw_err got %b expected 0", obs_err); end
        n_cmp++;
        if (obs_resp_cycle != 3) begin n_fail++; $display("FAIL rw_latency got %0d expected 3", obs_resp_cycle); end
        n_cmp++;
        if (obs_first_cyc != 1) begin n_fail++; $display("FAIL rw_cyc_start got %0d expected 1", obs_first_cyc); end
        n_cmp++;
        if (obs_adr !== 32'h100 || obs_we !== 1'b0 || obs_dat !== 32'd0) begin
            n_fail++; $display("FAIL rw_bus got adr=%h we=%b dat=%h expected 00000100/0/0", obs_adr, obs_we, obs_dat);
        end
        n_cmp++;
        if (obs_pulses != 1 || obs_ready_after !== 1'b1) begin
            n_fail++; $display("FAIL rw_pulse got pulses=%0d ready=%b expected 1/1", obs_pulses, obs_ready_after);
        end
    endtask

    task automatic test_byte_write_half_read();
        run_txn(32'h103, 1'b1, 2'd0, 32'h0000_00A5, 0, 1'b0, 1'b0, 32'd0);
        n_cmp++;
        if (obs_sel !== 4'b0001 || obs_dat !== 32'hA5A5A5A5 || obs_we !== 1'b1) begin
            n_fail++; $display("FAIL bw_bus got sel=%b dat=%h we=%b expected 0001/a5a5a5a5/1", obs_sel, obs_dat, obs_we);
        end
        n_cmp++;
        if (obs_rdata !== 32'd0 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL bw_resp got rdata=%h err=%b expected 0/0", obs_rdata, obs_err);
        end
        run_txn(32'h102, 1'b0, 2'd1, 32'd0, 0, 1'b0, 1'b0, 32'h11223344);
        n_cmp++;
        if (obs_sel !== 4'b0011) begin n_fail++; $display("FAIL hr_sel got %b expected 0011", obs_sel); end
        n_cmp++;
        if (obs_rdata !== 32'h0000_3344) begin n_fail++; $display("FAIL hr_rdata got %h expected 00003344", obs_rdata); end
    endtask

    task automatic test_misaligned();
        run_txn(32'h101, 1'b0, 2'd1, 32'd0, 0, 1'b0, 1'b0, 32'd0);
        n_cmp++;
        if (obs_attempts != 0) begin n_fail++; $display("FAIL mis_nocyc got attempts=%0d expected 0", obs_attempts); end
        n_cmp++;
        if (obs_resp_cycle != 2 || obs_err !== 1'b1) begin
            n_fail++; $display("FAIL mis_resp got cycle=%0d err=%b expected 2/1", obs_resp_cycle, obs_err);
        end
        n_cmp++;
        if (obs_pulses != 1 || obs_ready_after !== 1'b1) begin
            n_fail++; $display("FAIL mis_pulse got pulses=%0d ready=%b expected 1/1", obs_pulses, obs_ready_after);
        end
        run_txn(32'h0, 1'b1, 2'd3, 32'h1234, 0, 1'b0, 1'b0, 32'd0);
        n_cmp++;
        if (obs_attempts != 0 || obs_err !== 1'b1) begin
            n_fail++; $display("FAIL mis_size3 got attempts=%0d err=%b expected 0/1", obs_attempts, obs_err);
        end
        run_txn(32'h102, 1'b0, 2'd2, 32'd0, 0, 1'b0, 1'b0, 32'd0);
        n_cmp++;
        if (obs_attempts != 0 || obs_err !== 1'b1) begin
            n_fail++; $display("FAIL mis_word got attempts=%0d err=%b expected 0/1", obs_attempts, obs_err);
        end
    endtask

    task automatic test_retry();
        run_txn(32'h80, 1'b0, 2'd2, 32'd0, 3, 1'b0, 1'b0, 32'hCAFE_0001);
        n_cmp++;
        if (obs_attempts != 4 || obs_gap_bad) begin
            n_fail++; $display("FAIL rty3_attempts got attempts=%0d gap_bad=%0b expected 4/0", obs_attempts, obs_gap_bad);
        end
        n_cmp++;
        if (obs_err !== 1'b0 || obs_rdata !== 32'hCAFE_0001 || obs_resp_cycle != 12) begin
            n_fail++; $display("FAIL rty3_resp got err=%b rdata=%h cycle=%0d expected 0/cafe0001/12",
                               obs_err, obs_rdata, obs_resp_cycle);
        end
        run_txn(32'h84, 1'b1, 2'd2, 32'h5555_AAAA, 4, 1'b0, 1'b0, 32'd0);
        n_cmp++;
        if (obs_attempts != 4 || obs_err !== 1'b1 || obs_resp_cycle != 12) begin
            n_fail++; $display("FAIL rty4 got attempts=%0d err=%b cycle=%0d expected 4/1/12",
                               obs_attempts, obs_err, obs_resp_cycle);
        end
    endtask

    task automatic test_timeout();
        run_txn(32'h40, 1'b0, 2'd2, 32'd0, 0, 1'b0, 1'b1, 32'd0);
        n_cmp++;
        if (obs_cyc_cycles != TO || obs_attempts != 1) begin
            n_fail++; $display("FAIL timeout_cyc got cyc_cycles=%0d attempts=%0d expected %0d/1",
                               obs_cyc_cycles, obs_attempts, TO);
        end
        n_cmp++;
        if (obs_err !== 1'b1 || obs_resp_cycle != TO + 1) begin
            n_fail++; $display("FAIL timeout_resp got err=%b cycle=%0d expected 1/%0d", obs_err, obs_resp_cycle, TO + 1);
        end
    endtask

    task automatic test_err();
        run_txn(32'h10, 1'b0, 2'd0, 32'd0, 0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        n_cmp++;
        if (obs_err !== 1'b1 || obs_rdata !== 32'd0 || obs_resp_cycle != 3) begin
            n_fail++; $display("FAIL err_resp got err=%b rdata=%h cycle=%0d expected 1/0/3",
                               obs_err, obs_rdata, obs_resp_cycle);
        end
    endtask

    task automatic test_reset_mid();
        bit bad_valid;
        bad_valid = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 32'h200; req_we_i = 1'b0; req_size_i = 2'd2;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        n_cmp++;
        if (cyc_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_cyc_up got %b expected 1", cyc_o); end
        @(negedge clk_i);
        ack_i = 1'b1; dat_i = 32'h1234_5678; rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({cyc_o, stb_o, resp_valid_o} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_drop got cyc/stb/valid=%b expected 000", {cyc_o, stb_o, resp_valid_o});
        end
        @(negedge clk_i);
        ack_i = 1'b0; rst_i = 1'b1;
        #1;
        n_cmp++;
        if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_pre got %b expected 0", req_ready_o); end
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_post got %b expected 1", req_ready_o); end
        for (int i = 0; i < 3; i++) begin
            if (resp_valid_o !== 1'b0 || cyc_o !== 1'b0) bad_valid = 1'b1;
            @(negedge clk_i);
        end
        n_cmp++;
        if (bad_valid) begin n_fail++; $display("FAIL rstmid_no_resp got stray valid/cyc 1 expected 0"); end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] addr, wdata, rdat, e_rdata;
        logic [1:0]  size;
        logic        we, e_err;
        bit          ferr, mis;
        int          k, n, e_att;
        for (int i = 0; i < 30; i++) begin
            size  = 2'($urandom_range(0, 3));
            addr  = $urandom;
            if (size != 2'd3 && $urandom_range(0, 3) != 0) begin
                n = 1 << size;
                addr = addr - (addr % n);
            end
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            rdat  = $urandom;
            k     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            ferr  = ($urandom_range(0, 5) == 0);
            mis   = m_mis(addr, size);
            if (mis) begin
                e_att = 0; e_err = 1'b1; e_rdata = 32'd0;
            end else if (k > MR) begin
                e_att = MR + 1; e_err = 1'b1; e_rdata = 32'd0;
            end else begin
                e_att = k + 1; e_err = ferr;
                e_rdata = (ferr || we) ? 32'd0 : m_rdata(rdat, addr, size);
            end
            run_txn(addr, we, size, wdata, k, ferr, 1'b0, rdat);
            n_cmp++;
            if (obs_resp_cycle != (mis ? 2 : 3 * e_att) || obs_attempts != e_att) begin
                n_fail++; $display("FAIL rnd%0d_timing got cycle=%0d attempts=%0d expected %0d/%0d",
                                   i, obs_resp_cycle, obs_attempts, mis ? 2 : 3 * e_att, e_att);
            end
            n_cmp++;
            if (obs_err !== e_err || obs_rdata !== e_rdata) begin
                n_fail++; $display("FAIL rnd%0d_resp got err=%b rdata=%h expected %b/%h",
                                   i, obs_err, obs_rdata, e_err, e_rdata);
            end
            if (!mis) begin
                n_cmp++;
                if (obs_sel !== m_sel(addr, size) || obs_adr !== addr || obs_we !== we ||
                    obs_dat !== (we ? m_wdat(wdata, size) : 32'd0)) begin
                    n_fail++; $display("FAIL rnd%0d_bus got sel=%b adr=%h we=%b dat=%h expected %b/%h/%b/%h",
                                       i, obs_sel, obs_adr, obs_we, obs_dat, m_sel(addr, size), addr, we,
                                       we ? m_wdat(wdata, size) : 32'd0);
                end
                n_cmp++;
                if (!obs_stable || obs_gap_bad) begin
                    n_fail++; $display("FAIL rnd%0d_stable got stable=%0b gap_bad=%0b expected 1/0",
                                       i, obs_stable, obs_gap_bad);
                end
            end
            n_cmp++;
            if (obs_pulses != 1 || obs_ready_busy_bad || obs_ready_after !== 1'b1 || !obs_hold_ok) begin
                n_fail++; $display("FAIL rnd%0d_hs got pulses=%0d busy_ready=%0b ready_after=%b hold=%0b expected 1/0/1/1",
                                   i, obs_pulses, obs_ready_busy_bad, obs_ready_after, obs_hold_ok);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid_i = 1'b0; req_addr_i = 32'd0; req_we_i = 1'b0; req_size_i = 2'd0;
        req_wdata_i = 32'd0; dat_i = 32'd0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        rst_i = 1'b1;
        #2;
        test_reset();
        test_read_word();
        test_byte_write_half_read();
        test_misaligned();
        test_retry();
        test_timeout();
        test_err();
        test_reset_mid();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
